fifo_rd_stream: RTL
===================

# fifo_rd_stream

Read-side controller for the team's synchronous FIFO (chip select, read enable, registered read data, empty flag). It issues pops into the FIFO, absorbs the FIFO's one-cycle read latency, and presents the words as a valid/ready stream with back-pressure. Data order is preserved, no word is dropped or duplicated, and full throughput (one word per clock) is sustained when the sink is always ready.

## Interface
- DATA_WIDTH, 32, word width; must match the FIFO.
- CNT_WIDTH, 16, width of the delivered-word counter.

- clk  in  1  rising-edge clock; shared with the FIFO.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  pops are permitted while high.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  DATA_WIDTH  FIFO registered read data.
- fifo_cs  out  1  FIFO chip select; always equal to fifo_rd_en.
- fifo_rd_en  out  1  FIFO read enable (a pop request).
- m_valid  out  1  stream word valid.
- m_ready  in  1  sink accepts the word.
- m_data  out  DATA_WIDTH  stream word.
- pop_count  out  CNT_WIDTH  count of words delivered (handshakes completed).
- busy  out  1  high while a word is in flight or buffered.

## Operation
- FIFO contract:
  - A pop occurs on a rising edge where fifo_cs && fifo_rd_en && !fifo_empty.
  - The popped word is on fifo_data during the following cycle and holds until the next pop.
- State:
  - inflight (1 bit): set on the edge of a pop; meaning "fifo_data carries an uncaptured word this cycle".
  - 2-entry output buffer: head and skid registers, with occupancy occ in 0..2.
- deq = m_valid && m_ready.
- pop = enable && !fifo_empty && (occ + inflight - deq) < 2.
  - The calculation is combinational and uses 2-bit-plus-sign-safe arithmetic, so no underflow occurs.
  - fifo_rd_en = fifo_cs = pop.
  - The combinational path from m_ready to fifo_rd_en is intentional; it is required for full throughput.
- Capture: on each edge where inflight == 1, fifo_data is written into the buffer.
  - It goes to head if head is empty after this edge's dequeue; otherwise it goes to skid.
- Dequeue: on an edge with deq, head is consumed.
  - skid moves to head if it is occupied.
  - Capture and dequeue on the same edge are both honoured and occ is updated net.
- Outputs:
  - m_valid = (occ != 0).
  - m_data = head.
  - busy = (occ != 0) || inflight.
- pop_count increments by 1 on every deq edge and wraps from all-ones to 0.
- The occupancy invariant occ + inflight <= 2 holds at all times. An overflow of the buffer is a design error.

## Timing
- Reset values (rst_n low):
  - inflight 0, occ 0, head 0, skid 0.
  - m_valid 0, m_data 0, pop_count 0, busy 0.
  - fifo_rd_en and fifo_cs 0, forced low while rst_n is low.
- Latency: a pop on edge N gives m_valid high after edge N+1 (2 edges from pop to presentation).
- Throughput: with m_ready held high and FIFO non-empty, there is 1 pop and 1 deq per cycle in steady state.
- Back-pressure:
  - While m_valid && !m_ready, m_data and m_valid hold stable.
  - At most 2 words are buffered; pops stop when occ + inflight reaches 2.
- enable low: no new pops. The in-flight word is still captured and buffered words still drain.
- fifo_empty high: no pop that cycle. m_valid drops after the buffer drains.
- The FIFO going empty exactly as the last word is popped is handled: no extra pop is issued.
- Reset mid-operation: in-flight and buffered words are discarded. Those words are already popped from the FIFO and are lost by design.

## Test plan
- Basic: FIFO model preloaded with 1, 10, 100; enable=1, m_ready=1 -> stream 1, 10, 100 on consecutive cycles; first m_valid 2 edges after the first pop; pop_count=3; busy=0 after drain; no pop while empty.
- Streaming: 8 words 2**i (i=0..7) preloaded; m_ready=1 -> 8 handshakes in 8 consecutive cycles, correct order, pop_count=8.
- Back-pressure: 8 words preloaded; m_ready low for 5 cycles -> exactly 2 pops; m_data=1 held stable; after m_ready=1 all 8 words arrive in order, none duplicated.
- Random ready: m_ready toggled pseudo-randomly over 200 words -> scoreboard matches FIFO push order; occ never exceeds 2.
- Enable and empty: enable dropped while 1 word is in flight -> that word is still delivered and no further pops occur. FIFO empty with enable=1 -> fifo_rd_en stays 0 and m_valid=0.
- Reset and wrap: rst_n pulsed low with 2 words buffered -> all outputs return to reset values immediately. Separately, with CNT_WIDTH=4, 17 words delivered -> pop_count=1.

Source files
------------

// File: rtl/fifo_rd_stream_if.sv
// Bundles the FIFO read port and the outgoing valid/ready stream.
// The controller uses the master view; the FIFO/sink side uses the slave view.
interface fifo_rd_stream_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  fifo_cs;
  logic                  fifo_rd_en;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport master (
    output fifo_cs,
    output fifo_rd_en,
    input  fifo_empty,
    input  fifo_data,
    output m_valid,
    input  m_ready,
    output m_data
  );

  modport slave (
    input  fifo_cs,
    input  fifo_rd_en,
    output fifo_empty,
    output fifo_data,
    input  m_valid,
    output m_ready,
    input  m_data
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// Read-side controller for the synchronous FIFO: issues pops, absorbs the
// one-cycle read latency and presents words as a valid/ready stream.
// A two-entry head/skid buffer lets pops run one per clock while still
// tolerating back-pressure without ever dropping an already-popped word.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  fifo_rd_stream_if.master     bus,
  output logic [CNT_WIDTH-1:0] pop_count,
  output logic                 busy
);

  logic [1:0]            occ;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] skid;

  logic                  valid;
  logic                  deq;
  logic                  pop;
  logic [1:0]            occ_after_deq;
  logic [2:0]            level;

  // Pop decision: room is judged on the buffer level after this edge's
  // dequeue plus the word already in flight, so a draining sink keeps pops
  // flowing every cycle (this is the intended m_ready -> fifo_rd_en path).
  always_comb begin
    valid         = (occ != 2'd0);
    deq           = valid && bus.m_ready;
    occ_after_deq = occ - {1'b0, deq};
    level         = {1'b0, occ_after_deq} + {2'b0, inflight};
    pop           = rst_n && enable && !bus.fifo_empty && (level < 3'd2);
  end

  assign bus.fifo_rd_en = pop;
  assign bus.fifo_cs    = pop;
  assign bus.m_valid    = valid;
  assign bus.m_data     = head;
  assign busy           = valid || inflight;

  // Buffer, in-flight flag and delivered-word counter; the FIFO word that
  // lands this cycle goes to head if head frees up, otherwise to skid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight  <= 1'b0;
      occ       <= 2'd0;
      head      <= '0;
      skid      <= '0;
      pop_count <= '0;
    end else begin
      inflight <= pop;
      occ      <= occ_after_deq + {1'b0, inflight};
      if (deq && (occ == 2'd2)) begin
        head <= skid;
      end
      if (inflight) begin
        if (occ_after_deq == 2'd0) begin
          head <= bus.fifo_data;
        end else begin
          skid <= bus.fifo_data;
        end
      end
      if (deq) begin
        pop_count <= pop_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule
